// File: rtl/nios_handshake_nios2_qsys_0_oci_trace_capture.sv
// Trace capture buffer: circular store of {count, data} words with a CAPTURE/STOPPED/DONE controller.
// Optional loss counter enabled by defining OCI_TRACE_OVF_COUNT_EN.
module nios_handshake_nios2_qsys_0_oci_trace_capture #(
  parameter int DATA_W  = 30,
  parameter int COUNT_W = 4,
  parameter int DEPTH   = 16,
  parameter int WRAP    = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_W-1:0]           dct_buffer,
  input  logic [COUNT_W-1:0]          dct_count,
  input  logic                        dct_valid,
  input  logic                        test_ending,
  input  logic                        test_has_ended,
  input  logic                        rd_req,
  output logic [COUNT_W+DATA_W-1:0]   rd_data,
  output logic                        rd_valid,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        empty,
  output logic                        full,
  output logic                        capturing,
  output logic                        done,
  output logic [15:0]                 ovf_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = COUNT_W + DATA_W;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_STOPPED = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [EW-1:0]   mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic [LW-1:0]   level_s;
  logic            wr_en_s, rd_en_s, mem_we_s, lost_s;

  assign wr_en_s = dct_valid && (dct_count != COUNT_W'(0)) && (state_r == ST_CAPTURE);
  assign rd_en_s = rd_req && !empty && (state_r != ST_DONE);

  // Next pointers/level; a full write overwrites the oldest entry or is dropped depending on WRAP.
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    level_s  = level;
    mem_we_s = 1'b0;
    lost_s   = 1'b0;
    if (wr_en_s && rd_en_s) begin
      mem_we_s = 1'b1;
      wr_ptr_s = wr_ptr_r + AW'(1);
      rd_ptr_s = rd_ptr_r + AW'(1);
    end else if (wr_en_s) begin
      if (!full) begin
        mem_we_s = 1'b1;
        wr_ptr_s = wr_ptr_r + AW'(1);
        level_s  = level + LW'(1);
      end else if (WRAP != 0) begin
        mem_we_s = 1'b1;
        wr_ptr_s = wr_ptr_r + AW'(1);
        rd_ptr_s = rd_ptr_r + AW'(1);
        lost_s   = 1'b1;
      end else begin
        lost_s   = 1'b1;
      end
    end else if (rd_en_s) begin
      rd_ptr_s = rd_ptr_r + AW'(1);
      level_s  = level - LW'(1);
    end else begin
      level_s  = level;
    end
  end

  // Controller next state; DONE is only reachable from STOPPED.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CAPTURE: begin
        if (test_ending || test_has_ended) state_s = ST_STOPPED;
        else                               state_s = ST_CAPTURE;
      end
      ST_STOPPED: begin
        if (test_has_ended && empty) state_s = ST_DONE;
        else                         state_s = ST_STOPPED;
      end
      ST_DONE:    state_s = ST_DONE;
      default:    state_s = ST_CAPTURE;
    endcase
  end

  // Storage array carries no reset; it is invisible while empty.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_r[wr_ptr_r] <= {dct_count, dct_buffer};
  end

  // State, pointers and all registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_CAPTURE;
      wr_ptr_r  <= AW'(0);
      rd_ptr_r  <= AW'(0);
      level     <= LW'(0);
      empty     <= 1'b1;
      full      <= 1'b0;
      capturing <= 1'b1;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= EW'(0);
    end else begin
      state_r   <= state_s;
      wr_ptr_r  <= wr_ptr_s;
      rd_ptr_r  <= rd_ptr_s;
      level     <= level_s;
      empty     <= (level_s == LW'(0));
      full      <= (level_s == LW'(DEPTH));
      capturing <= (state_s == ST_CAPTURE);
      done      <= (state_s == ST_DONE);
      rd_valid  <= rd_en_s;
      if (rd_en_s) rd_data <= mem_r[rd_ptr_r];
    end
  end

`ifdef OCI_TRACE_OVF_COUNT_EN
  logic [15:0] ovf_r;

  // Saturating count of entries lost to a full buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             ovf_r <= 16'h0000;
    else if (lost_s && (ovf_r != 16'hFFFF))   ovf_r <= ovf_r + 16'h0001;
  end

  assign ovf_count = ovf_r;
`else
  logic unused_lost_s;
  assign unused_lost_s = lost_s;
  assign ovf_count     = 16'h0000;
`endif

endmodule

// File: tb/tb_nios_handshake_nios2_qsys_0_oci_trace_capture.sv
// Scoreboard bench: two DEPTH=4 instances (WRAP=1 and WRAP=0) driven in lockstep against queue models.
module tb_nios_handshake_nios2_qsys_0_oci_trace_capture;
  localparam int DW = 30;
  localparam int CW = 4;
  localparam int D  = 4;
  localparam int EW = CW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          dct_valid = 1'b0, test_ending = 1'b0, test_has_ended = 1'b0, rd_req = 1'b0;
  logic [DW-1:0] dct_buffer = '0;
  logic [CW-1:0] dct_count = '0;

  logic [EW-1:0] rd_data_w, rd_data_d;
  logic          rd_valid_w, rd_valid_d, empty_w, empty_d, full_w, full_d;
  logic          capturing_w, capturing_d, done_w, done_d;
  logic [2:0]    level_w, level_d;
  logic [15:0]   ovf_w, ovf_d;

  nios_handshake_nios2_qsys_0_oci_trace_capture #(.DATA_W(DW), .COUNT_W(CW), .DEPTH(D), .WRAP(1)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_req(rd_req),
    .rd_data(rd_data_w), .rd_valid(rd_valid_w), .level(level_w), .empty(empty_w), .full(full_w),
    .capturing(capturing_w), .done(done_w), .ovf_count(ovf_w));

  nios_handshake_nios2_qsys_0_oci_trace_capture #(.DATA_W(DW), .COUNT_W(CW), .DEPTH(D), .WRAP(0)) dut_drop (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_req(rd_req),
    .rd_data(rd_data_d), .rd_valid(rd_valid_d), .level(level_d), .empty(empty_d), .full(full_d),
    .capturing(capturing_d), .done(done_d), .ovf_count(ovf_d));

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] mq_w[$], mq_d[$], sb_w[$], sb_d[$];
  int            lost_w = 0, lost_d = 0;
  int            mstate = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ovf_exp(input int lost);
`ifdef OCI_TRACE_OVF_COUNT_EN
    return (lost > 65535) ? 16'hFFFF : 16'(lost);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_status();
    check_eq("level_w", 64'(level_w), 64'(mq_w.size()));
    check_eq("level_d", 64'(level_d), 64'(mq_d.size()));
    check_eq("empty_w", 64'(empty_w), 64'(mq_w.size() == 0));
    check_eq("empty_d", 64'(empty_d), 64'(mq_d.size() == 0));
    check_eq("full_w", 64'(full_w), 64'(mq_w.size() == D));
    check_eq("full_d", 64'(full_d), 64'(mq_d.size() == D));
    check_eq("capturing_w", 64'(capturing_w), 64'(mstate == 0));
    check_eq("capturing_d", 64'(capturing_d), 64'(mstate == 0));
    check_eq("done_w", 64'(done_w), 64'(mstate == 2));
    check_eq("done_d", 64'(done_d), 64'(mstate == 2));
    check_eq("ovf_w", 64'(ovf_w), 64'(ovf_exp(lost_w)));
    check_eq("ovf_d", 64'(ovf_d), 64'(ovf_exp(lost_d)));
  endtask

  // One clock of stimulus: update the models, push expected pops, then check outputs after the edge.
  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic rr, input logic te, input logic th);
    logic wr, rd, emp;
    dct_valid = v; dct_count = c; dct_buffer = d; rd_req = rr; test_ending = te; test_has_ended = th;
    emp = (mq_w.size() == 0);
    wr  = v && (c != 4'd0) && (mstate == 0);
    rd  = rr && !emp && (mstate != 2);
    if (rd) begin
      sb_w.push_back(mq_w.pop_front());
      sb_d.push_back(mq_d.pop_front());
    end
    if (wr) begin
      if (mq_w.size() < D) mq_w.push_back({c, d});
      else begin mq_w.delete(0); mq_w.push_back({c, d}); lost_w++; end
      if (mq_d.size() < D) mq_d.push_back({c, d});
      else lost_d++;
    end
    case (mstate)
      0:       if (te || th) mstate = 1;
      1:       if (th && emp) mstate = 2;
      default: mstate = mstate;
    endcase
    @(posedge clk); #1;
    check_eq("rd_valid_w", 64'(rd_valid_w), 64'(rd));
    check_eq("rd_valid_d", 64'(rd_valid_d), 64'(rd));
    if (rd_valid_w) begin
      if (sb_w.size() == 0) check_eq("sb_w_pending", 64'(sb_w.size()), 64'd1);
      else check_eq("rd_data_w", 64'(rd_data_w), 64'(sb_w.pop_front()));
    end
    if (rd_valid_d) begin
      if (sb_d.size() == 0) check_eq("sb_d_pending", 64'(sb_d.size()), 64'd1);
      else check_eq("rd_data_d", 64'(rd_data_d), 64'(sb_d.pop_front()));
    end
    check_status();
  endtask

  task automatic idle(input logic te, input logic th);
    cycle(1'b0, 4'd0, 30'd0, 1'b0, te, th);
  endtask

  task automatic wr(input logic [CW-1:0] c, input logic [DW-1:0] d);
    cycle(1'b1, c, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && mq_w.size() != 0; i++) pop();
    check_eq("drained", 64'(level_w), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dct_valid = 1'b0; rd_req = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    mq_w.delete(); mq_d.delete(); sb_w.delete(); sb_d.delete();
    lost_w = 0; lost_d = 0; mstate = 0;
    #12;
    check_eq("rst_rd_valid", 64'(rd_valid_w), 64'd0);
    check_eq("rst_rd_data", 64'(rd_data_w), 64'd0);
    check_status();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Three in-order entries with one-cycle pop latency.
    wr(4'd1, 30'h0A1); wr(4'd1, 30'h0A2); wr(4'd1, 30'h0A3);
    pop(); pop(); pop();
    check_eq("after3_empty", 64'(empty_w), 64'd1);

    // Six writes into four slots: WRAP keeps 3..6, drop keeps 1..4; a zero-count word is ignored.
    for (int i = 1; i <= 6; i++) begin
      wr(CW'(i), DW'(32'h100 + i));
      if (i == 2) cycle(1'b1, 4'd0, 30'h3FF, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0, 1'b0);
    drain();

    // Write+read on empty (level 0 -> 1), then on full (stays 4, no loss).
    cycle(1'b1, 4'd2, 30'h200, 1'b1, 1'b0, 1'b0);
    wr(4'd3, 30'h201); wr(4'd4, 30'h202); wr(4'd5, 30'h203);
    cycle(1'b1, 4'd6, 30'h204, 1'b1, 1'b0, 1'b0);
    drain();

    // Random traffic while capturing.
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), CW'($urandom_range(0, 3)), DW'($urandom),
            1'($urandom_range(0, 1)), 1'b0, 1'b0);
    drain();

    // Stop sequence: third write after test_ending is ignored, DONE follows the emptying pop.
    wr(4'd7, 30'h300); wr(4'd8, 30'h301);
    idle(1'b1, 1'b0);
    cycle(1'b1, 4'd9, 30'h302, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b1);
    check_eq("done_not_yet", 64'(done_w), 64'd0);
    idle(1'b0, 1'b1);
    check_eq("done_set", 64'(done_w), 64'd1);
    cycle(1'b1, 4'd1, 30'h303, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // Capture-to-stopped with test_has_ended while empty: STOPPED first, DONE a cycle later.
    do_reset();
    idle(1'b0, 1'b1);
    check_eq("th_stopped_first", 64'(done_w), 64'd0);
    idle(1'b0, 1'b1);

    // Asynchronous reset while rd_valid is high.
    do_reset();
    wr(4'd1, 30'h400); wr(4'd2, 30'h401);
    pop();
    check_eq("pre_rst_rd_valid", 64'(rd_valid_w), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("async_rd_valid", 64'(rd_valid_w), 64'd0);
    check_eq("async_empty", 64'(empty_w), 64'd1);
    check_eq("async_capturing", 64'(capturing_w), 64'd1);
    do_reset();
    wr(4'd3, 30'h402);
    pop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
